// File: rtl/m_cond_stage_if.sv
// m_cond_stage_if: decoder-side and execute-side handshake bundle for the condition stage
interface m_cond_stage_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instruction;
  logic [3:0]  in_cond;
  logic        in_sets_flags;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instruction;
  logic        out_execute;
  logic        out_illegal;
  logic        out_sets_flags;
  modport master (
    output in_valid, in_instruction, in_cond, in_sets_flags, out_ready,
    input  in_ready, out_valid, out_instruction, out_execute, out_illegal, out_sets_flags
  );
  modport slave (
    input  in_valid, in_instruction, in_cond, in_sets_flags, out_ready,
    output in_ready, out_valid, out_instruction, out_execute, out_illegal, out_sets_flags
  );
endinterface

// File: rtl/m_cond_stage.sv
// m_cond_stage: resolves each decoded instruction's condition against NZCV and tracks in-flight flag writers
module m_cond_stage #(
  parameter int MAX_PENDING = 3,
  parameter int CNT_W       = $clog2(MAX_PENDING + 1)
) (
  input  logic             clk,
  input  logic             rst,
  m_cond_stage_if.slave    bus,
  input  logic             wb_flags_we_i,
  input  logic [3:0]       wb_flags_i,
  input  logic             flush_i,
  output logic [3:0]       flags_o,
  output logic [CNT_W-1:0] pending_o
);
  localparam logic [3:0] AL = 4'd14;
  localparam logic [3:0] NV = 4'd15;
  logic             valid_q, exec_q, ill_q, sf_q;
  logic [31:0]      insn_q;
  logic [3:0]       flags_q;
  logic [CNT_W-1:0] pend_q, pend_d;
  logic             n, z, c, v, pass, stall, accept, inc;
  assign {n, z, c, v} = flags_q;
  // condition check uses only the architectural flags; stalls guarantee they are final
  always_comb begin
    pass = 1'b0;
    case (bus.in_cond)
      4'd0:  pass = z;
      4'd1:  pass = !z;
      4'd2:  pass = c;
      4'd3:  pass = !c;
      4'd4:  pass = n;
      4'd5:  pass = !n;
      4'd6:  pass = v;
      4'd7:  pass = !v;
      4'd8:  pass = c & !z;
      4'd9:  pass = !c | z;
      4'd10: pass = n == v;
      4'd11: pass = n != v;
      4'd12: pass = !z & (n == v);
      4'd13: pass = z | (n != v);
      4'd14: pass = 1'b1;
      default: pass = 1'b0;
    endcase
  end
  assign stall = (bus.in_cond != AL && bus.in_cond != NV && pend_q != '0)
               | (bus.in_sets_flags && pend_q == CNT_W'(MAX_PENDING));
  assign bus.in_ready = (!valid_q | bus.out_ready) & !stall & !flush_i;
  assign accept       = bus.in_valid & bus.in_ready;
  assign inc          = accept & bus.in_sets_flags & pass;
  // pending next state: flush clears, simultaneous inc/dec cancel, dec saturates at zero
  always_comb begin
    pend_d = flush_i ? '0
           : (inc && !wb_flags_we_i) ? pend_q + CNT_W'(1)
           : (!inc && wb_flags_we_i && pend_q != '0) ? pend_q - CNT_W'(1)
           : pend_q;
  end
  // output register, flag register and pending counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      insn_q  <= '0;
      exec_q  <= 1'b0;
      ill_q   <= 1'b0;
      sf_q    <= 1'b0;
      flags_q <= '0;
      pend_q  <= '0;
    end else begin
      if (flush_i) valid_q <= 1'b0;
      else if (accept) valid_q <= 1'b1;
      else if (bus.out_ready) valid_q <= 1'b0;
      if (accept) begin
        insn_q <= bus.in_instruction;
        exec_q <= pass;
        ill_q  <= bus.in_cond == NV;
        sf_q   <= bus.in_sets_flags & pass;
      end
      if (wb_flags_we_i) flags_q <= wb_flags_i;
      pend_q <= pend_d;
    end
  end
  assign bus.out_valid       = valid_q;
  assign bus.out_instruction = insn_q;
  assign bus.out_execute     = exec_q;
  assign bus.out_illegal     = ill_q;
  assign bus.out_sets_flags  = sf_q;
  assign flags_o             = flags_q;
  assign pending_o           = pend_q;
endmodule

// File: tb/tb_m_cond_stage.sv
// tb_m_cond_stage: directed vectors with hand-computed expectations for the condition stage
module tb_m_cond_stage;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wb_we = 1'b0;
  logic       flush = 1'b0;
  logic [3:0] wb_flags = 4'b0000;
  logic [3:0] flags;
  logic [1:0] pending;
  int checks = 0;
  int fails = 0;
  always #5 clk = ~clk;
  m_cond_stage_if bus();
  m_cond_stage dut (
    .clk(clk), .rst(rst), .bus(bus.slave),
    .wb_flags_we_i(wb_we), .wb_flags_i(wb_flags), .flush_i(flush),
    .flags_o(flags), .pending_o(pending)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic offer(input logic [3:0] c, input logic sf, input logic [31:0] w);
    bus.in_valid = 1'b1;
    bus.in_cond = c;
    bus.in_sets_flags = sf;
    bus.in_instruction = w;
  endtask
  logic [3:0] conds [8] = '{4'd10, 4'd11, 4'd12, 4'd13, 4'd8, 4'd9, 4'd2, 4'd3};
  logic       exps  [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
  initial begin
    bus.in_valid = 1'b0;
    bus.in_cond = 4'd14;
    bus.in_sets_flags = 1'b0;
    bus.in_instruction = '0;
    bus.out_ready = 1'b1;
    step;
    step;
    chk("rst_valid", bus.out_valid, 0);
    chk("rst_insn", bus.out_instruction, 0);
    chk("rst_exec", bus.out_execute, 0);
    chk("rst_ill", bus.out_illegal, 0);
    chk("rst_sf", bus.out_sets_flags, 0);
    chk("rst_flags", flags, 0);
    chk("rst_pend", pending, 0);
    rst = 1'b0;
    offer(4'd14, 1'b0, 32'hA000_0001);
    #1 chk("al_ready", bus.in_ready, 1);
    step;
    bus.in_valid = 1'b0;
    chk("al_valid", bus.out_valid, 1);
    chk("al_exec", bus.out_execute, 1);
    chk("al_insn", bus.out_instruction, 32'hA000_0001);
    chk("al_pend", pending, 0);
    step;
    chk("al_drain", bus.out_valid, 0);
    wb_we = 1'b1;
    wb_flags = 4'b0100;
    step;
    wb_we = 1'b0;
    chk("z_flags", flags, 4'b0100);
    chk("dec_sat0", pending, 0);
    offer(4'd0, 1'b0, 32'hB000_0000);
    step;
    chk("eq_exec", bus.out_execute, 1);
    chk("eq_ill", bus.out_illegal, 0);
    offer(4'd1, 1'b0, 32'hB000_0001);
    #1 chk("ne_ready", bus.in_ready, 1);
    step;
    bus.in_valid = 1'b0;
    chk("ne_exec", bus.out_execute, 0);
    chk("ne_ill", bus.out_illegal, 0);
    chk("ne_insn", bus.out_instruction, 32'hB000_0001);
    step;
    offer(4'd14, 1'b1, 32'hC000_0000);
    step;
    chk("sf_pend1", pending, 1);
    chk("sf_out", bus.out_sets_flags, 1);
    offer(4'd0, 1'b0, 32'hC000_0001);
    #1 chk("eq_stall0", bus.in_ready, 0);
    step;
    chk("eq_stall1", bus.in_ready, 0);
    wb_we = 1'b1;
    wb_flags = 4'b0000;
    #1 chk("eq_stall_wb", bus.in_ready, 0);
    step;
    wb_we = 1'b0;
    chk("wb_pend0", pending, 0);
    chk("wb_flags", flags, 0);
    chk("eq_go", bus.in_ready, 1);
    step;
    bus.in_valid = 1'b0;
    chk("eq2_valid", bus.out_valid, 1);
    chk("eq2_insn", bus.out_instruction, 32'hC000_0001);
    chk("eq2_exec_newflags", bus.out_execute, 0);
    step;
    offer(4'd14, 1'b1, 32'hD000_0000);
    step;
    step;
    chk("b2b_pend2", pending, 2);
    wb_we = 1'b1;
    step;
    wb_we = 1'b0;
    chk("incdec_pend", pending, 2);
    step;
    chk("b2b_pend3", pending, 3);
    chk("full_stall", bus.in_ready, 0);
    bus.in_valid = 1'b0;
    bus.in_sets_flags = 1'b0;
    #1 chk("full_nosf_ready", bus.in_ready, 1);
    offer(4'd14, 1'b1, 32'hD000_0004);
    wb_we = 1'b1;
    #1 chk("full_wb_stall", bus.in_ready, 0);
    step;
    wb_we = 1'b0;
    chk("full_wb_pend2", pending, 2);
    step;
    bus.in_valid = 1'b0;
    chk("fourth_pend3", pending, 3);
    chk("fourth_insn", bus.out_instruction, 32'hD000_0004);
    wb_we = 1'b1;
    step;
    step;
    step;
    step;
    wb_we = 1'b0;
    chk("drain_pend0", pending, 0);
    bus.out_ready = 1'b0;
    offer(4'd15, 1'b1, 32'hE000_000F);
    #1 chk("nv_ready", bus.in_ready, 1);
    step;
    chk("nv_valid", bus.out_valid, 1);
    chk("nv_ill", bus.out_illegal, 1);
    chk("nv_exec", bus.out_execute, 0);
    chk("nv_sf", bus.out_sets_flags, 0);
    chk("nv_pend", pending, 0);
    offer(4'd14, 1'b0, 32'hE000_0001);
    #1 chk("hold_ready", bus.in_ready, 0);
    step;
    chk("hold_valid", bus.out_valid, 1);
    chk("hold_insn", bus.out_instruction, 32'hE000_000F);
    bus.out_ready = 1'b1;
    #1 chk("rel_ready", bus.in_ready, 1);
    step;
    chk("rel_insn", bus.out_instruction, 32'hE000_0001);
    chk("rel_ill", bus.out_illegal, 0);
    offer(4'd14, 1'b1, 32'hF000_0000);
    step;
    step;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    chk("pre_flush_pend", pending, 2);
    chk("pre_flush_valid", bus.out_valid, 1);
    flush = 1'b1;
    wb_we = 1'b1;
    wb_flags = 4'b1001;
    offer(4'd14, 1'b0, 32'hF000_0009);
    #1 chk("flush_ready", bus.in_ready, 0);
    step;
    flush = 1'b0;
    wb_we = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    chk("flush_valid", bus.out_valid, 0);
    chk("flush_pend", pending, 0);
    chk("flush_flags", flags, 4'b1001);
    for (int i = 0; i < 8; i++) begin
      offer(conds[i], 1'b0, 32'h1000_0000 + 32'(i));
      step;
      chk($sformatf("cond%0d_exec", conds[i]), bus.out_execute, 32'(exps[i]));
    end
    bus.in_valid = 1'b0;
    step;
    offer(4'd14, 1'b1, 32'h2000_0000);
    step;
    bus.in_valid = 1'b0;
    chk("pre_rst_pend", pending, 1);
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", bus.out_valid, 0);
    chk("arst_pend", pending, 0);
    chk("arst_flags", flags, 0);
    chk("arst_insn", bus.out_instruction, 0);
    step;
    rst = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
